// File: rtl/ras_predecode_pkg.sv
// Shared types for the RAS pre-decoder: RISC-V opcode / RVC funct fields,
// the control-flow class struct, the tracking FSM states and a link helper.
package ras_predecode_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_JALR   = 3'b000;

  localparam logic [1:0] Q_RV32    = 2'b11;
  localparam logic [1:0] C_Q1      = 2'b01;
  localparam logic [1:0] C_Q2      = 2'b10;
  localparam logic [2:0] C1_JAL    = 3'b001;
  localparam logic [2:0] C1_J      = 3'b101;
  localparam logic [2:0] C1_BEQZ   = 3'b110;
  localparam logic [2:0] C1_BNEZ   = 3'b111;
  localparam logic [2:0] C2_JR     = 3'b100;

  typedef struct packed {
    logic push;
    logic pop;
    logic snapshot;
    logic is_return;
  } cf_class_t;

  typedef enum logic [1:0] {
    ST_NORMAL,
    ST_FULL,
    ST_FLUSH
  } state_t;

  // x1 (ra) and x5 (t0) are the ABI link registers.
  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

endpackage

// File: rtl/ras_predecode_if.sv
// Fetch-side handshake plus the RAS command bus driven by ras_predecode.
// master: fetch stage / environment view; slave: the pre-decoder view.
interface ras_predecode_if #(
  parameter int unsigned PC_W = 32
);
  logic            fetch_valid;
  logic            fetch_ready;
  logic [PC_W-1:0] fetch_pc;
  logic [31:0]     fetch_instr;
  logic            ras_push;
  logic            ras_pop;
  logic [PC_W-1:0] ras_new_addr;
  logic            ras_branch_fetched;
  logic            ras_branch_retired;
  logic            pred_return;

  modport master (
    output fetch_valid, fetch_pc, fetch_instr,
    input  fetch_ready, ras_push, ras_pop, ras_new_addr,
           ras_branch_fetched, ras_branch_retired, pred_return
  );

  modport slave (
    input  fetch_valid, fetch_pc, fetch_instr,
    output fetch_ready, ras_push, ras_pop, ras_new_addr,
           ras_branch_fetched, ras_branch_retired, pred_return
  );
endinterface

// File: rtl/ras_predecode_link_classify.sv
// Combinational instruction -> cf_class_t decoder (module ras_link_classify).
// Compressed decode is built only with RAS_PREDECODE_RVC_EN defined.
module ras_link_classify
  import ras_predecode_pkg::*;
(
  input  logic [31:0] instr,
  output cf_class_t   cls
);

  logic [4:0] rd;
  logic [4:0] rs1;
  logic       rd_link;
  logic       rs1_link;
  logic       unused_bits;

  assign rd          = instr[11:7];
  assign rs1         = instr[19:15];
  assign rd_link     = is_link(rd);
  assign rs1_link    = is_link(rs1);
  assign unused_bits = ^instr[31:20];

  // Decode push/pop/snapshot from opcode and link-register usage.
  always_comb begin
    cls = '0;
    if (instr[1:0] == Q_RV32) begin
      case (instr[6:0])
        OP_JAL: begin
          cls.snapshot = 1'b1;
          cls.push     = rd_link;
        end
        OP_JALR: begin
          if (instr[14:12] == F3_JALR) begin
            cls.snapshot = 1'b1;
            cls.push     = rd_link;
            // Pop when rs1 is a link reg, except the same-reg push-only case.
            cls.pop      = rs1_link && !(rd_link && (rd == rs1));
          end
        end
        OP_BRANCH: cls.snapshot = 1'b1;
        default: ;
      endcase
    end
`ifdef RAS_PREDECODE_RVC_EN
    else if (instr[1:0] == C_Q1) begin
      case (instr[15:13])
        C1_JAL: begin
          cls.snapshot = 1'b1;
          cls.push     = 1'b1;
        end
        C1_J, C1_BEQZ, C1_BNEZ: cls.snapshot = 1'b1;
        default: ;
      endcase
    end else if (instr[1:0] == C_Q2 && instr[15:13] == C2_JR &&
                 instr[6:2] == 5'd0 && instr[11:7] != 5'd0) begin
      cls.snapshot = 1'b1;
      if (instr[12]) begin
        cls.push = 1'b1;
        cls.pop  = (instr[11:7] == 5'd5);
      end else begin
        cls.pop  = is_link(instr[11:7]);
      end
    end
`endif
    cls.is_return = cls.pop;
  end

endmodule

// File: rtl/ras_predecode.sv
// Fetch-stage control-flow pre-decoder driving the RAS: one register stage
// of push/pop/snapshot strobes, in-flight tracking and fetch back-pressure.
// Optional macro: RAS_PREDECODE_RVC_EN enables compressed decode (+2 link).
module ras_predecode
  import ras_predecode_pkg::*;
#(
  parameter int unsigned MAX_IDS = 8,
  parameter int unsigned PC_W    = 32,
  localparam int unsigned CNT_W  = $clog2(MAX_IDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  ras_predecode_if.slave   bus,
  input  logic             gc_fetch_flush,
  input  logic             cf_retire,
  output logic [CNT_W-1:0] outstanding
);

  cf_class_t       cls;
  state_t          state_q, state_d;
  logic            compressed;
  logic [PC_W-1:0] step;
  logic            accept;
  logic            push_q, pop_q, snap_q, ret_q;
  logic [PC_W-1:0] addr_q;
  logic            fetched, retired;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W:0]  occupancy;

  ras_link_classify u_classify (
    .instr (bus.fetch_instr),
    .cls   (cls)
  );

`ifdef RAS_PREDECODE_RVC_EN
  assign compressed = (bus.fetch_instr[1:0] != Q_RV32);
`else
  assign compressed = 1'b0;
`endif
  assign step   = compressed ? PC_W'(2) : PC_W'(4);
  assign accept = bus.fetch_valid & bus.fetch_ready & ~gc_fetch_flush;

  // Flush masks the already-registered strobes and blocks the load, so the
  // stage stays quiet in the flush cycle and the one after it.
  assign fetched = snap_q & ~gc_fetch_flush;
  assign retired = cf_retire & (outstanding != '0) & ~gc_fetch_flush;

  assign bus.ras_push           = push_q & ~gc_fetch_flush;
  assign bus.ras_pop            = pop_q & ~gc_fetch_flush;
  assign bus.pred_return        = ret_q & ~gc_fetch_flush;
  assign bus.ras_branch_fetched = fetched;
  assign bus.ras_branch_retired = retired;
  assign bus.ras_new_addr       = addr_q;
  assign bus.fetch_ready        = (state_q == ST_NORMAL);

  // Single register stage between acceptance and the RAS strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_q <= 1'b0;
      pop_q  <= 1'b0;
      snap_q <= 1'b0;
      ret_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      push_q <= accept & cls.push;
      pop_q  <= accept & cls.pop;
      snap_q <= accept & cls.snapshot;
      ret_q  <= accept & cls.is_return;
      if (accept) addr_q <= bus.fetch_pc + step;
    end
  end

  // Next in-flight count; flush mirrors the RAS snapshot FIFO reset.
  always_comb begin
    count_d = outstanding;
    if (gc_fetch_flush)        count_d = '0;
    else if (fetched && !retired) count_d = outstanding + CNT_W'(1);
    else if (!fetched && retired) count_d = outstanding - CNT_W'(1);
  end

  // Occupancy includes the snapshot being accepted now so FULL blocks the
  // very next fetch rather than one cycle late.
  assign occupancy = {1'b0, count_d} + (CNT_W+1)'(accept & cls.snapshot);

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_NORMAL;
      outstanding <= '0;
    end else begin
      state_q     <= state_d;
      outstanding <= count_d;
    end
  end

  // Back-pressure FSM next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL: if (occupancy == (CNT_W+1)'(MAX_IDS)) state_d = ST_FULL;
      ST_FULL:   if (retired) state_d = ST_NORMAL;
      ST_FLUSH:  state_d = ST_NORMAL;
      default:   state_d = ST_NORMAL;
    endcase
    if (gc_fetch_flush) state_d = ST_FLUSH;
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.ras_branch_fetched && !bus.ras_branch_retired &&
      outstanding == CNT_W'(MAX_IDS)));

endmodule

// File: tb/tb_ras_predecode.sv
// Directed self-checking bench for ras_predecode.
module tb_ras_predecode;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       gc_fetch_flush;
  logic       cf_retire;
  logic [3:0] outstanding;
  int         n_chk = 0;
  int         n_bad = 0;

  localparam logic [31:0] I_JAL_RA = 32'h008000EF;
  localparam logic [31:0] I_RET    = 32'h00008067;
  localparam logic [31:0] I_CORO   = 32'h000280E7;
  localparam logic [31:0] I_BEQ    = 32'h00000063;
  localparam logic [31:0] I_ADDI   = 32'h00000013;

  ras_predecode_if #(.PC_W(32)) bus ();

  ras_predecode #(.MAX_IDS(8), .PC_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .gc_fetch_flush (gc_fetch_flush),
    .cf_retire      (cf_retire),
    .outstanding    (outstanding)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] instr);
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = pc;
    bus.fetch_instr = instr;
    cycle();
    bus.fetch_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n           = 1'b0;
    gc_fetch_flush  = 1'b0;
    cf_retire       = 1'b0;
    bus.fetch_valid = 1'b0;
    bus.fetch_pc    = '0;
    bus.fetch_instr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_push", bus.ras_push, 0);
    check("rst_pop", bus.ras_pop, 0);
    check("rst_addr", bus.ras_new_addr, 0);
    check("rst_bf", bus.ras_branch_fetched, 0);
    check("rst_cnt", outstanding, 0);
    rst_n = 1'b1;
    cycle();
    check("rst_ready", bus.fetch_ready, 1);

    // call
    do_fetch(32'h100, I_JAL_RA);
    check("call_push", bus.ras_push, 1);
    check("call_pop", bus.ras_pop, 0);
    check("call_addr", bus.ras_new_addr, 32'h104);
    check("call_bf", bus.ras_branch_fetched, 1);
    check("call_cnt_pre", outstanding, 0);
    cycle();
    check("call_cnt", outstanding, 1);
    check("call_push_1cyc", bus.ras_push, 0);
    check("call_bf_1cyc", bus.ras_branch_fetched, 0);

    // return
    do_fetch(32'h104, I_RET);
    check("ret_pop", bus.ras_pop, 1);
    check("ret_pred", bus.pred_return, 1);
    check("ret_push", bus.ras_push, 0);
    cycle();
    check("ret_cnt", outstanding, 2);

    // coroutine swap
    do_fetch(32'h200, I_CORO);
    check("coro_pop", bus.ras_pop, 1);
    check("coro_push", bus.ras_push, 1);
    check("coro_addr", bus.ras_new_addr, 32'h204);
    cycle();

    // plain branch and non control flow
    do_fetch(32'h208, I_BEQ);
    check("br_bf", bus.ras_branch_fetched, 1);
    check("br_push", bus.ras_push, 0);
    check("br_pop", bus.ras_pop, 0);
    cycle();
    check("br_cnt", outstanding, 4);
    do_fetch(32'h20C, I_ADDI);
    check("addi_bf", bus.ras_branch_fetched, 0);
    check("addi_push", bus.ras_push, 0);

    // address wrap
    do_fetch(32'hFFFF_FFFC, I_JAL_RA);
    check("wrap_push", bus.ras_push, 1);
    check("wrap_addr", bus.ras_new_addr, 32'h0);
    cycle();
    check("wrap_cnt", outstanding, 5);

    // drain, then retire at zero
    cf_retire = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("drain_ret", bus.ras_branch_retired, 1);
      cycle();
    end
    cf_retire = 1'b0;
    check("drain_cnt", outstanding, 0);
    cf_retire = 1'b1;
    #1;
    check("zero_ret", bus.ras_branch_retired, 0);
    cycle();
    cf_retire = 1'b0;
    check("zero_cnt", outstanding, 0);

    // fill to MAX_IDS
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = 32'h500;
    bus.fetch_instr = I_BEQ;
    for (int i = 0; i < 8; i++) begin
      check("full_ready_pre", bus.fetch_ready, 1);
      cycle();
    end
    check("full_ready", bus.fetch_ready, 0);
    check("full_cnt7", outstanding, 7);
    check("full_bf_last", bus.ras_branch_fetched, 1);
    cycle();
    bus.fetch_valid = 1'b0;
    check("full_blocked_bf", bus.ras_branch_fetched, 0);
    check("full_cnt8", outstanding, 8);
    check("full_ready_hold", bus.fetch_ready, 0);
    cf_retire = 1'b1;
    #1;
    check("full_ret", bus.ras_branch_retired, 1);
    cycle();
    cf_retire = 1'b0;
    check("full_exit_cnt", outstanding, 7);
    check("full_exit_ready", bus.fetch_ready, 1);

    // flush kills the pending call and clears the count
    do_fetch(32'h400, I_JAL_RA);
    gc_fetch_flush = 1'b1;
    cf_retire      = 1'b1;
    #1;
    check("fl_push_now", bus.ras_push, 0);
    check("fl_bf_now", bus.ras_branch_fetched, 0);
    check("fl_ret_drop", bus.ras_branch_retired, 0);
    cycle();
    gc_fetch_flush = 1'b0;
    cf_retire      = 1'b0;
    #1;
    check("fl_push_next", bus.ras_push, 0);
    check("fl_bf_next", bus.ras_branch_fetched, 0);
    check("fl_cnt", outstanding, 0);
    check("fl_ready", bus.fetch_ready, 0);
    cycle();
    check("fl_ready_back", bus.fetch_ready, 1);
    check("fl_cnt_after", outstanding, 0);

`ifdef RAS_PREDECODE_RVC_EN
    do_fetch(32'h300, 32'h0000_8082);
    check("rvc_jr_pop", bus.ras_pop, 1);
    check("rvc_jr_pred", bus.pred_return, 1);
    check("rvc_jr_push", bus.ras_push, 0);
    cycle();
    do_fetch(32'h300, 32'h0000_2001);
    check("rvc_jal_push", bus.ras_push, 1);
    check("rvc_jal_addr", bus.ras_new_addr, 32'h302);
    check("rvc_jal_pop", bus.ras_pop, 0);
`else
    do_fetch(32'h300, 32'h0000_8082);
    check("norvc_pop", bus.ras_pop, 0);
    check("norvc_bf", bus.ras_branch_fetched, 0);
`endif
    cycle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
